// File: rtl/rr_priority_arbiter_4.sv
// Four-requester arbiter with a registered one-hot grant, encoded index and valid flag.
// Fixed priority (highest index wins) or rotating round-robin, with an optional
// per-grant hold limit that revokes the grant and pulses timeout.
module rr_priority_arbiter_4 #(
    parameter int unsigned RR_MODE  = 1,
    parameter int unsigned MAX_HOLD = 8,
    parameter int unsigned HW       = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout
);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    localparam logic [HW-1:0] HoldMax = HW'(MAX_HOLD);
    localparam logic [HW-1:0] HoldSat = {HW{1'b1}};
    localparam logic [HW-1:0] HoldOne = HW'(1);

    state_e        state_q, state_d;
    logic [3:0]    gnt_q, gnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [1:0]    ptr_q, ptr_d;
    logic          timeout_q, timeout_d;

    logic [1:0]    search_base;
    logic [1:0]    cand;
    logic          win_found;
    logic [1:0]    win_idx;

    // Winner search: ptr, ptr-1, ptr-2, ptr-3 (mod 4); fixed mode always starts at 3.
    always_comb begin
        win_found   = 1'b0;
        win_idx     = 2'b00;
        search_base = (RR_MODE != 0) ? ptr_q : 2'd3;
        cand        = search_base;
        for (int k = 0; k < 4; k++) begin
            cand = search_base - 2'(k);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Next-state logic: grant from idle, hold or release while granted.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        idx_d     = idx_q;
        hold_d    = hold_q;
        ptr_d     = ptr_q;
        timeout_d = 1'b0;
        case (state_q)
            StIdle: begin
                if (win_found) begin
                    gnt_d   = 4'b0001 << win_idx;
                    idx_d   = win_idx;
                    hold_d  = HoldOne;
                    state_d = StGrant;
                end
            end
            StGrant: begin
                if (!req[idx_q] || (MAX_HOLD != 0 && hold_q == HoldMax)) begin
                    // A dropped request takes precedence, so timeout only if still requesting.
                    timeout_d = req[idx_q];
                    gnt_d     = 4'b0000;
                    idx_d     = 2'b00;
                    hold_d    = '0;
                    state_d   = StIdle;
                    // Just-served requester becomes lowest priority.
                    ptr_d     = (RR_MODE != 0) ? idx_q - 2'd1 : 2'd3;
                end else if (hold_q != HoldSat) begin
                    hold_d = hold_q + HoldOne;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            gnt_q     <= 4'b0000;
            idx_q     <= 2'b00;
            hold_q    <= '0;
            ptr_q     <= 2'd3;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            idx_q     <= idx_d;
            hold_q    <= hold_d;
            ptr_q     <= ptr_d;
            timeout_q <= timeout_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = idx_q;
    assign gnt_valid = |gnt_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_priority_arbiter_4.sv
// Directed bench for rr_priority_arbiter_4 using three parameterisations:
// a: fixed priority, unlimited hold; b: round-robin, hold 2; c: round-robin, hold 4.
module tb_rr_priority_arbiter_4;

    logic       clk;
    logic       rst_n;
    logic [3:0] req_a, req_b, req_c;
    logic [3:0] gnt_a, gnt_b, gnt_c;
    logic [1:0] idx_a, idx_b, idx_c;
    logic       vld_a, vld_b, vld_c;
    logic       to_a, to_b, to_c;

    int n_checks = 0;
    int n_fail   = 0;

    rr_priority_arbiter_4 #(.RR_MODE(0), .MAX_HOLD(0), .HW(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .req(req_a), .gnt(gnt_a), .gnt_idx(idx_a),
        .gnt_valid(vld_a), .timeout(to_a)
    );

    rr_priority_arbiter_4 #(.RR_MODE(1), .MAX_HOLD(2), .HW(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .req(req_b), .gnt(gnt_b), .gnt_idx(idx_b),
        .gnt_valid(vld_b), .timeout(to_b)
    );

    rr_priority_arbiter_4 #(.RR_MODE(1), .MAX_HOLD(4), .HW(4)) dut_c (
        .clk(clk), .rst_n(rst_n), .req(req_c), .gnt(gnt_c), .gnt_idx(idx_c),
        .gnt_valid(vld_c), .timeout(to_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [1:0] enc(input logic [3:0] g);
        logic [1:0] r;
        r = 2'b00;
        for (int i = 0; i < 4; i++) if (g[i]) r = 2'(i);
        return r;
    endfunction

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req_a = 4'b0; req_b = 4'b0; req_c = 4'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
    endtask

    // Round-robin with all requests held, hold limit 2.
    logic [3:0] seq_gnt [13] = '{4'b1000, 4'b1000, 4'b0000, 4'b0100, 4'b0100, 4'b0000,
                                 4'b0010, 4'b0010, 4'b0000, 4'b0001, 4'b0001, 4'b0000,
                                 4'b1000};
    logic       seq_to  [13] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1,
                                 1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        rst_n = 1'b1;
        // Reset state and fixed priority with unlimited hold.
        do_reset();
        check_eq("rst_gnt", 8'(gnt_a), 8'h0);
        check_eq("rst_idx", 8'(idx_a), 8'h0);
        check_eq("rst_vld", 8'(vld_a), 8'h0);
        check_eq("rst_to", 8'(to_a), 8'h0);
        req_a = 4'b1011;
        tick();
        check_eq("fp_gnt", 8'(gnt_a), 8'h8);
        check_eq("fp_idx", 8'(idx_a), 8'h3);
        check_eq("fp_vld", 8'(vld_a), 8'h1);
        for (int i = 0; i < 20; i++) begin
            tick();
            check_eq("fp_hold_gnt", 8'(gnt_a), 8'h8);
            check_eq("fp_hold_to", 8'(to_a), 8'h0);
        end

        // Idle with no requests, then a single request.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            tick();
            check_eq("idle_gnt", 8'(gnt_a), 8'h0);
            check_eq("idle_idx", 8'(idx_a), 8'h0);
            check_eq("idle_vld", 8'(vld_a), 8'h0);
        end
        req_a = 4'b0100;
        tick();
        check_eq("single_gnt", 8'(gnt_a), 8'h4);
        check_eq("single_idx", 8'(idx_a), 8'h2);

        // Round-robin rotation with timeouts.
        do_reset();
        req_b = 4'b1111;
        for (int i = 0; i < 13; i++) begin
            tick();
            check_eq($sformatf("rr_gnt%0d", i), 8'(gnt_b), 8'(seq_gnt[i]));
            check_eq($sformatf("rr_idx%0d", i), 8'(idx_b), 8'(enc(seq_gnt[i])));
            check_eq($sformatf("rr_vld%0d", i), 8'(vld_b), 8'(|seq_gnt[i]));
            check_eq($sformatf("rr_to%0d", i), 8'(to_b), 8'(seq_to[i]));
        end

        // Requester drops: release without timeout, then lower requester after one idle.
        do_reset();
        req_c = 4'b1001;
        repeat (3) begin
            tick();
            check_eq("drop_gnt3", 8'(gnt_c), 8'h8);
        end
        req_c = 4'b0001;
        tick();
        check_eq("drop_rel_gnt", 8'(gnt_c), 8'h0);
        check_eq("drop_rel_to", 8'(to_c), 8'h0);
        tick();
        check_eq("drop_next_gnt", 8'(gnt_c), 8'h1);
        check_eq("drop_next_idx", 8'(idx_c), 8'h0);

        // Drop on the same cycle the hold limit is reached: no timeout.
        do_reset();
        req_c = 4'b0100;
        repeat (4) begin
            tick();
            check_eq("prec_gnt", 8'(gnt_c), 8'h4);
        end
        req_c = 4'b0000;
        tick();
        check_eq("prec_rel_gnt", 8'(gnt_c), 8'h0);
        check_eq("prec_rel_to", 8'(to_c), 8'h0);
        tick();
        check_eq("prec_after_to", 8'(to_c), 8'h0);

        // Hold limit 4 with request kept high: timeout after 4 cycles.
        do_reset();
        req_c = 4'b0100;
        repeat (4) tick();
        check_eq("lim4_gnt", 8'(gnt_c), 8'h4);
        tick();
        check_eq("lim4_rel_gnt", 8'(gnt_c), 8'h0);
        check_eq("lim4_to", 8'(to_c), 8'h1);

        // Async reset mid-grant, pointer returns to 3.
        do_reset();
        req_c = 4'b1000;
        tick();
        check_eq("ar_g3", 8'(gnt_c), 8'h8);
        req_c = 4'b0010;
        tick();
        check_eq("ar_rel", 8'(gnt_c), 8'h0);
        tick();
        check_eq("ar_g1", 8'(gnt_c), 8'h2);
        check_eq("ar_i1", 8'(idx_c), 8'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("ar_async_gnt", 8'(gnt_c), 8'h0);
        check_eq("ar_async_vld", 8'(vld_c), 8'h0);
        check_eq("ar_async_idx", 8'(idx_c), 8'h0);
        do_reset();
        req_c = 4'b1111;
        tick();
        check_eq("ar_ptr_gnt", 8'(gnt_c), 8'h8);
        check_eq("ar_ptr_idx", 8'(idx_c), 8'h3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_priority_arbiter_4.md
Name: rr_priority_arbiter_4

Overview:
- Shares one downstream resource between 4 requesters.
- Uses the team's 4-to-2 priority-encoding convention: a one-hot grant, a 2-bit encoded index, and a valid flag.
- Registered grant with a per-grant hold limit.
- Two modes, selectable by parameter: fixed priority (highest index wins, identical to the encoder) or rotating round-robin for fairness.

Parameters:
- RR_MODE, 1, 0 = fixed priority (req[3] highest); 1 = round-robin rotating pointer.
- MAX_HOLD, 8, maximum consecutive grant cycles per winner; 0 = unlimited.
- HW, 4, hold counter width; must satisfy 2^HW > MAX_HOLD.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  4  request vector; bit i = requester i; level-sensitive.
- gnt  output  4  one-hot grant, registered; all zero when idle.
- gnt_idx  output  2  encoded index of the current winner; 2'b00 when idle.
- gnt_valid  output  1  high iff gnt != 0.
- timeout  output  1  one-cycle pulse when a grant is revoked by MAX_HOLD.

Behaviour:
- Reset (rst_n=0, async, immediate):
  - State = IDLE; gnt=0, gnt_idx=0, gnt_valid=0, timeout=0; hold_cnt=0; ptr=2'd3.
- Reset release: first arbitration happens at the first rising edge with rst_n=1.
- FSM has two states, IDLE and GRANT.
- IDLE:
  - If req==0, stay in IDLE with outputs 0.
  - Else the winner is computed combinationally and registered: next edge sets gnt=1<<w, gnt_idx=w, gnt_valid=1, hold_cnt=1, state=GRANT.
  - Latency from req to gnt is 1 cycle.
- Winner selection:
  - RR_MODE=0: the highest set bit of req.
  - RR_MODE=1: search order ptr, ptr-1, ptr-2, ptr-3 (mod 4); the first set bit wins.
  - With ptr=3 this is identical to fixed priority.
- GRANT, release conditions:
  - (a) req[w]==0 sampled at the edge. Release.
  - (b) MAX_HOLD!=0, hold_cnt==MAX_HOLD and req[w]==1. Release and assert timeout=1 for exactly that next cycle.
- GRANT, on release: next edge sets gnt=0, gnt_valid=0, gnt_idx=0, hold_cnt=0, state=IDLE.
  - If RR_MODE=1, ptr <= w-1 (mod 4), so the just-served requester becomes lowest priority.
  - If RR_MODE=0, ptr stays at 3.
- GRANT, otherwise: hold_cnt increments, saturating at 2^HW-1; gnt is stable.
  - Other requests arriving during GRANT are ignored and never preempt.
- Mandatory idle cycle: exactly 1 idle cycle (gnt_valid=0) between consecutive grants, even when requests are pending. This is the hand-off bubble for the resource mux.
- Requester behaviour after release:
  - A requester released by timeout that keeps req high re-competes normally.
  - In RR mode it has lowest priority, so any other pending request wins first.
- Simultaneous events:
  - If req[w] drops in the same cycle hold_cnt==MAX_HOLD, condition (a) takes precedence and timeout stays 0.
- Invariants:
  - Grant and index never change mid-grant; gnt is always one-hot or zero.
  - gnt_idx always equals the encoding of gnt.
- Reset mid-grant: all outputs clear immediately (async), without waiting for a clock edge; ptr returns to 3.
- Unknown/X on req is treated as a design error; the bench shall not drive it.

Test Plan:
- Reset, then req=4'b1011 held with RR_MODE=0, MAX_HOLD=0 -> one cycle later gnt=4'b1000, gnt_idx=2'b11, gnt_valid=1. Grant held indefinitely, timeout never asserts.
- RR_MODE=1, req=4'b1111 held constantly, MAX_HOLD=2 -> winner sequence 3,2,1,0,3. Each grant lasts 2 cycles with timeout pulsed on its release, separated by one idle cycle.
- RR_MODE=1, grant to 3 with req=4'b1001; drop req[3] after 3 cycles -> gnt clears next edge with timeout=0. After one idle cycle gnt=4'b0001, gnt_idx=2'b00.
- req=4'b0000 for 10 cycles after reset -> gnt=0, gnt_idx=0, gnt_valid=0 throughout. Then req=4'b0100 -> gnt=4'b0100, gnt_idx=2'b10 after 1 cycle.
- MAX_HOLD=4; req[2] drops exactly on the cycle hold_cnt==4 -> release with timeout=0 (precedence of condition a).
- Assert rst_n=0 mid-grant (gnt=4'b0010) between clock edges -> gnt, gnt_valid and gnt_idx go to 0 immediately. After release, req=4'b1111 in RR mode grants index 3 first (ptr reset to 3).
